alu_pkt_responder: RTL

ALU_PKT_RESPONDER -- requirements
Module: alu_pkt_responder

---
 rtl/alu_pkt_responder_if.sv | 31 +++
 rtl/alu_pkt_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_pkt_responder_if.sv
// Stimulus and response handshake channels of the ALU packet responder.
// master = packet source / response sink, slave = responder.
interface alu_pkt_responder_if;
    logic        stim_valid;
    logic        stim_ready;
    logic [60:0] stim_pkt;
    logic        resp_valid;
    logic        resp_ready;
    logic [84:0] resp_pkt;
    logic        resp_pass;

    modport master (
        output stim_valid,
        output stim_pkt,
        output resp_ready,
        input  stim_ready,
        input  resp_valid,
        input  resp_pkt,
        input  resp_pass
    );

    modport slave (
        input  stim_valid,
        input  stim_pkt,
        input  resp_ready,
        output stim_ready,
        output resp_valid,
        output resp_pkt,
        output resp_pass
    );
endinterface

// File: rtl/alu_pkt_responder.sv
// Applies a stimulus packet to an ALU, samples its result LATENCY edges later and returns a
// response packet with a pass flag. Define ALU_PKT_RESPONDER_SCB_CNT_EN for pass/fail tallies.
module alu_pkt_responder #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_pkt_responder_if.slave   bus,
    output logic                 alu_rst,
    output logic                 alu_ce,
    output logic                 alu_mode,
    output logic                 alu_cin,
    output logic [3:0]           alu_cmd,
    output logic [1:0]           alu_inp_valid,
    output logic [WIDTH-1:0]     alu_opa,
    output logic [WIDTH-1:0]     alu_opb,
    input  logic [2*WIDTH-1:0]   alu_res,
    input  logic                 alu_cout,
    input  logic                 alu_oflow,
    input  logic                 alu_err,
    input  logic                 alu_neg,
    input  logic                 alu_zero,
    input  logic [2:0]           alu_gle,
    output logic [15:0]          pass_cnt,
    output logic [15:0]          fail_cnt
);

    // state | meaning
    // IDLE  | ready for a stimulus packet
    // WAIT  | ALU driven, counting edges until the result is sampled
    // RESP  | response presented, waiting for resp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        accept;
    logic        sample;
    logic        match;
    logic [84:0] resp_q;
    logic        pass_q;
    logic [15:0] res_in;

    // Result bits beyond the fixed 16-bit packet field are not reported.
    assign res_in = 16'(alu_res);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        sample         = 1'b0;
        bus.stim_ready = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.stim_ready = 1'b1;
                if (bus.stim_valid) begin
                    accept     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == LAST_CNT) begin
                    sample     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reserved bits [60:58] and the unused packet bits take no part in the comparison.
    always_comb begin
        match = (res_in    == resp_q[23:8]) &&
                (alu_cout  == resp_q[7])    &&
                (alu_gle   == resp_q[4:2])  &&
                (alu_oflow == resp_q[6])    &&
                (alu_err   == resp_q[5])    &&
                (alu_neg   == resp_q[1])    &&
                (alu_zero  == resp_q[0]);
    end

    // resp_q[60:0] holds the stored stimulus; the upper field is written at the sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            resp_q        <= '0;
            pass_q        <= 1'b0;
            alu_rst       <= 1'b0;
            alu_ce        <= 1'b0;
            alu_mode      <= 1'b0;
            alu_cmd       <= '0;
            alu_inp_valid <= '0;
            alu_opa       <= '0;
            alu_opb       <= '0;
            alu_cin       <= 1'b0;
        end else begin
            if (accept) begin
                cnt           <= '0;
                resp_q[60:0]  <= bus.stim_pkt;
                alu_rst       <= bus.stim_pkt[49];
                alu_ce        <= bus.stim_pkt[48];
                alu_mode      <= bus.stim_pkt[47];
                alu_cmd       <= bus.stim_pkt[46:43];
                alu_inp_valid <= bus.stim_pkt[42:41];
                alu_opa       <= WIDTH'(bus.stim_pkt[40:33]);
                alu_opb       <= WIDTH'(bus.stim_pkt[32:25]);
                alu_cin       <= bus.stim_pkt[24];
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
            if (sample) begin
                resp_q[84:61] <= {res_in, alu_cout, alu_oflow, alu_err,
                                  alu_gle, alu_neg, alu_zero};
                pass_q        <= match;
            end
        end
    end

    assign bus.resp_pkt  = resp_q;
    assign bus.resp_pass = pass_q;

`ifdef ALU_PKT_RESPONDER_SCB_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (sample) begin
            if (match) begin
                if (pass_cnt != 16'hFFFF) begin
                    pass_cnt <= pass_cnt + 16'd1;
                end
            end else begin
                if (fail_cnt != 16'hFFFF) begin
                    fail_cnt <= fail_cnt + 16'd1;
                end
            end
        end
    end
`else
    assign pass_cnt = 16'd0;
    assign fail_cnt = 16'd0;
`endif

endmodule
